sort_frame_ctrl: RTL

// Initiator/front-end for the parallel-array sorter (fsm_sort-style start/done interface).

---
 rtl/sort_frame_ctrl_pkg.sv | 22 ++
 rtl/sort_frame_ctrl_if.sv | 34 +++
 rtl/sort_frame_ctrl_wdt.sv | 39 +++
 rtl/sort_frame_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sort_frame_ctrl_pkg.sv
// Shared definitions for the frame controller and the sorter core it supervises.
package sort_pkg;

  localparam int SORT_N       = 6;
  localparam int SORT_WIDTH   = 8;
  localparam int SORT_TIMEOUT = 64;

  typedef logic [SORT_WIDTH-1:0] sort_word_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    KICK    = 2'd1,
    WAIT    = 2'd2,
    DRAIN   = 2'd3
  } sort_ctl_state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_frame_ctrl_if.sv
// Stream, sorter and status signals of the frame controller; master = controller side.
// Handshake: a word moves on a rising edge where valid && ready; valid never waits for ready,
// and a source holding valid keeps its data stable until the transfer happens.
interface sort_frame_if #(
  parameter int N     = 6,
  parameter int WIDTH = 8
);

  logic                     s_valid;
  logic                     s_ready;
  logic [WIDTH-1:0]         s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [WIDTH-1:0]         m_data;
  logic                     m_last;
  logic                     sort_start;
  logic [N-1:0][WIDTH-1:0]  sort_data_in;
  logic                     sort_done;
  logic [N-1:0][WIDTH-1:0]  sort_data_sorted;
  logic                     busy;
  logic                     err;
  logic                     clr_err;

  modport master (
    input  s_valid, s_data, m_ready, sort_done, sort_data_sorted, clr_err,
    output s_ready, m_valid, m_data, m_last, sort_start, sort_data_in, busy, err
  );

  modport slave (
    output s_valid, s_data, m_ready, sort_done, sort_data_sorted, clr_err,
    input  s_ready, m_valid, m_data, m_last, sort_start, sort_data_in, busy, err
  );

endinterface

// File: rtl/sort_frame_ctrl_wdt.sv
// Saturating watchdog for the sorter: expired_o once TIMEOUT-1 enabled cycles have elapsed.
module sort_wdt
  import sort_pkg::*;
#(
  parameter int TIMEOUT = SORT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CW    = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority so a KICK always restarts a full window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/sort_frame_ctrl.sv
// Frame front-end for the parallel sorter: collect N words, kick the sorter, replay the result.
module sort_frame_ctrl
  import sort_pkg::*;
#(
  parameter int N       = SORT_N,
  parameter int WIDTH   = SORT_WIDTH,
  parameter int TIMEOUT = SORT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  sort_frame_if.master    bus,
  output sort_ctl_state_t state_o
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  sort_ctl_state_t         state_q, state_d;
  logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [N-1:0][WIDTH-1:0] frame_q, frame_d;
  logic [N-1:0][WIDTH-1:0] obuf_q, obuf_d;
  logic [WIDTH-1:0]        m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic                    err_q, err_d;
  logic                    wdt_clr, wdt_en, wdt_expired;
  logic                    timeout;

  assign wdt_clr = (state_q == KICK);
  assign wdt_en  = (state_q == WAIT);

  sort_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wdt_clr),
    .en_i      (wdt_en),
    .expired_o (wdt_expired)
  );

  // A done in the expiring cycle still counts as success.
  assign timeout = (state_q == WAIT) && wdt_expired && !bus.sort_done;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    frame_d   = frame_q;
    obuf_d    = obuf_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    err_d     = err_q;

    if (bus.clr_err) begin
      err_d = 1'b0;
    end
    if (timeout) begin
      err_d = 1'b1;
    end

    case (state_q)
      COLLECT: begin
        // The frame register is the sorter input, so it is frozen once we leave COLLECT.
        if (bus.s_valid) begin
          frame_d[wr_cnt_q] = bus.s_data;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            state_d  = KICK;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      KICK: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.sort_done) begin
          obuf_d    = bus.sort_data_sorted;
          rd_cnt_d  = '0;
          m_data_d  = bus.sort_data_sorted[0];
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          state_d   = DRAIN;
        end else if (wdt_expired) begin
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        if (bus.m_ready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = COLLECT;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            m_data_d = obuf_q[rd_cnt_d];
            m_last_d = (rd_cnt_d == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      frame_q   <= '0;
      obuf_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      frame_q   <= frame_d;
      obuf_q    <= obuf_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  assign bus.s_ready      = (state_q == COLLECT);
  assign bus.busy         = (state_q != COLLECT);
  assign bus.sort_start   = (state_q == KICK);
  assign bus.sort_data_in = frame_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_data       = m_data_q;
  assign bus.m_last       = m_last_q;
  assign bus.err          = err_q;
  assign state_o          = state_q;

endmodule
